spi_agent: RTL



---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 22 ++
 rtl/spi_agent.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the host and the agent.
// Mode numbering follows the usual {cpol,cpha} convention.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  function automatic spi_mode_e spi_mode(input logic cpol,
                                         input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for asynchronous SPI pins.
// Reset value is chosen per pin so an idle bus looks idle after reset.
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {N{RST_VAL}};
    else     sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/spi_agent.sv
// Peripheral-side SPI endpoint, oversampled in the clk domain.
// Full-duplex bytes in all four modes with a one-deep tx holding register.
module spi_agent
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       selected
);

  logic sck_s2, cs_s2, mosi_s2;
  logic sck_s3_q, cs_s3_q;

  spi_sync #(.N(2), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d_i(sck), .q_o(sck_s2)
  );
  spi_sync #(.N(2), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d_i(cs_n), .q_o(cs_s2)
  );
  spi_sync #(.N(2), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s2)
  );

  spi_mode_e mode;
  logic      samp_lead;
  logic      lead, trail, sel_fall, sel_rise;
  logic      samp, shft, load;

  assign mode = spi_mode(cpol, cpha);

  always_comb begin
    samp_lead = 1'b0;
    unique case (mode)
      SPI_MODE0, SPI_MODE2: samp_lead = 1'b1;
      default:              samp_lead = 1'b0;
    endcase
  end

  logic       sel_q, sel_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       urun_q, urun_d;

  assign lead     = (sck_s2 ^ sck_s3_q) & (sck_s2 == ~cpol);
  assign trail    = (sck_s2 ^ sck_s3_q) & (sck_s2 == cpol);
  assign sel_fall = ~cs_s2 & cs_s3_q;
  assign sel_rise = cs_s2 & ~cs_s3_q;

  assign samp = sel_q & (samp_lead ? lead : trail);
  assign shft = sel_q & (samp_lead ? trail : lead);
  // cpha=0 needs the MSB on miso before the first leading edge
  assign load = (sel_fall & ~cpha) | (shft & (bit_cnt_q == 3'd0));

  always_comb begin
    sel_d      = sel_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    full_d     = full_q;
    urun_d     = 1'b0;

    if (tx_valid && !full_q) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end

    if (sel_fall || sel_rise) begin
      sel_d      = sel_fall;
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
    end else if (samp) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s2};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = {rx_shift_q[6:0], mosi_s2};
        rx_valid_d = 1'b1;
      end
    end

    // load looks at the pre-write state: no same-cycle bypass
    if (load) begin
      if (full_q) begin
        tx_shift_d = hold_q;
        full_d     = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
        urun_d     = 1'b1;
      end
    end else if (shft) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s3_q   <= 1'b0;
      cs_s3_q    <= 1'b1;
      sel_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_shift_q <= IDLE_BYTE;
      hold_q     <= 8'h00;
      full_q     <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      sck_s3_q   <= sck_s2;
      cs_s3_q    <= cs_s2;
      sel_q      <= sel_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      urun_q     <= urun_d;
    end
  end

  assign miso        = tx_shift_q[7];
  assign miso_oe     = sel_q;
  assign selected    = sel_q;
  assign tx_ready    = ~full_q;
  assign tx_underrun = urun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

endmodule
